// File: rtl/memory.sv
// Memory-access pipeline stage: issues data-bus loads/stores, holds them until data_ok,
// aligns store data/strobes and extends load data for writeback.
package common;
    typedef logic [63:0] word_t;
    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

    typedef struct packed {
        logic        valid;
        word_t       addr;
        msize_t      size;
        logic [7:0]  strobe;
        word_t       data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        word_t       data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        memread;
        logic        memwrite;
        word_t       writedata;
        word_t       aluout;
        msize_t      msize;
        logic        mem_unsigned;
        logic [4:0]  dst;
        word_t       pc;
        logic [31:0] raw_instr;
        logic [11:0] csr;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        memread;
        logic        memwrite;
        word_t       writedata;
        word_t       aluout;
        msize_t      msize;
        logic        mem_unsigned;
        logic [4:0]  dst;
        word_t       pc;
        logic [31:0] raw_instr;
        logic [11:0] csr;
        word_t       result;
        logic        misalign;
    } memory_data_t;
endpackage

module memory
    import common::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          stall_in,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM,
    output logic          memstall
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t     state;
    word_t      rbuf;
    logic       is_mem, mis_bits, misalign, acc;
    logic [2:0] off;
    logic [7:0] strobe_base;
    word_t      rdata, raw, ext;
    logic       unused;

    // Sequencing relies solely on data_ok.
    assign unused = dresp.addr_ok;

    assign off    = dataE.aluout[2:0];
    assign is_mem = dataE.valid & (dataE.memread | dataE.memwrite);

    always_comb begin
        mis_bits    = 1'b0;
        strobe_base = 8'h01;
        case (dataE.msize)
            MSIZE1: begin mis_bits = 1'b0;      strobe_base = 8'h01; end
            MSIZE2: begin mis_bits = off[0];    strobe_base = 8'h03; end
            MSIZE4: begin mis_bits = |off[1:0]; strobe_base = 8'h0F; end
            MSIZE8: begin mis_bits = |off;      strobe_base = 8'hFF; end
            default: ;
        endcase
    end

    assign misalign = is_mem & mis_bits;
    assign acc      = is_mem & ~misalign;
    assign memstall = (state != DONE) & acc & ~dresp.data_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rbuf  <= '0;
        end else begin
            case (state)
                IDLE, WAIT: begin
                    if (acc && dresp.data_ok) begin
                        // The completed word must survive until M/W unfreezes.
                        if (stall_in) begin
                            state <= DONE;
                            rbuf  <= dresp.data;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (acc) begin
                        state <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: if (!stall_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dreq        = '0;
        dreq.valid  = (state != DONE) & acc;
        dreq.addr   = dataE.aluout;
        dreq.size   = dataE.msize;
        dreq.strobe = dataE.memwrite ? 8'(strobe_base << off) : 8'h00;
        dreq.data   = dataE.writedata << {off, 3'b000};
    end

    assign rdata = (state == DONE) ? rbuf : dresp.data;
    assign raw   = rdata >> {off, 3'b000};

    always_comb begin
        ext = raw;
        case (dataE.msize)
            MSIZE1: ext = {{56{raw[7]  & ~dataE.mem_unsigned}}, raw[7:0]};
            MSIZE2: ext = {{48{raw[15] & ~dataE.mem_unsigned}}, raw[15:0]};
            MSIZE4: ext = {{32{raw[31] & ~dataE.mem_unsigned}}, raw[31:0]};
            MSIZE8: ext = raw;
            default: ;
        endcase
    end

    always_comb begin
        dataM              = '0;
        dataM.valid        = dataE.valid & ~memstall;
        dataM.regwrite     = dataE.regwrite & ~misalign;
        dataM.memtoreg     = dataE.memtoreg;
        dataM.memread      = dataE.memread;
        dataM.memwrite     = dataE.memwrite;
        dataM.writedata    = dataE.writedata;
        dataM.aluout       = dataE.aluout;
        dataM.msize        = dataE.msize;
        dataM.mem_unsigned = dataE.mem_unsigned;
        dataM.dst          = dataE.dst;
        dataM.pc           = dataE.pc;
        dataM.raw_instr    = dataE.raw_instr;
        dataM.csr          = dataE.csr;
        dataM.result       = dataE.memtoreg ? ext : dataE.aluout;
        dataM.misalign     = misalign;
    end
endmodule
